// File: rtl/game_pkg.sv
// game_pkg -- shared encodings for the two-snake game controller.
//
// Holds the game state encoding, the speed-level (clk_rate) encoding, the
// winner encoding and the bit positions of the control keys inside the
// 12-bit keystroke bus. Imported by game_ctrl.
package game_pkg;

  // Game state, also exported on the state port of game_ctrl.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } game_state_t;

  // Speed level. Lower code = faster movement.
  typedef enum logic [1:0] {
    RATE_4HZ     = 2'b00,
    RATE_2HZ     = 2'b01,
    RATE_1HZ     = 2'b10,
    RATE_HALF_HZ = 2'b11
  } clk_rate_t;

  // Outcome reported once the game is over.
  typedef enum logic [1:0] {
    WIN_NONE   = 2'b00,
    WIN_SNAKE1 = 2'b01,
    WIN_SNAKE2 = 2'b10,
    WIN_TIE    = 2'b11
  } winner_t;

  // Control key bit indices inside keystroke[11:0].
  localparam int KEY_CLEAR = 8;
  localparam int KEY_PAUSE = 9;
  localparam int KEY_FAST  = 10;
  localparam int KEY_SLOW  = 11;

endpackage

// File: rtl/key_edge.sv
// key_edge -- turns one raw, asynchronous key into a single-cycle press event.
//
// Path: 2-flop synchroniser -> optional debounce filter -> rising-edge pulse.
// Optional feature macro: GAME_CTRL_DEBOUNCE_EN. When defined, the
// synchronised level must be stable for DEB_CYCLES consecutive cycles before
// the filtered level follows it; otherwise the edge detector works directly
// on the synchronised level.
//
// Ports:
//   clk   in  1  system clock
//   rst   in  1  asynchronous active-high reset
//   key   in  1  raw key level
//   press out 1  one-cycle pulse per press (combinational from flops)
//
// A key that is already held when reset releases produces no event: the
// detector only arms after it has seen the synchronised key low.
module key_edge #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  logic       sync1;
  logic       sync2;
  logic [1:0] settle;   // fills with ones once sync2 carries real key data
  logic       armed;
  logic       lvl;
  logic       lvl_prev;

`ifdef GAME_CTRL_DEBOUNCE_EN
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [DW-1:0] deb_cnt;
  logic          filt;

  // Counts consecutive cycles in which sync2 disagrees with the filtered
  // level; any agreeing cycle restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
      filt    <= 1'b0;
    end else if (sync2 == filt) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
      filt    <= sync2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign lvl = filt;
`else
  // DEB_CYCLES only shapes the debounce filter, which is not built here.
  logic unused_deb;
  assign unused_deb = (DEB_CYCLES != 0);
  assign lvl        = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      settle   <= 2'b00;
      armed    <= 1'b0;
      lvl_prev <= 1'b0;
    end else begin
      sync1    <= key;
      sync2    <= sync1;
      settle   <= {settle[0], 1'b1};
      armed    <= armed | (settle[1] & ~sync2);
      lvl_prev <= lvl;
    end
  end

  assign press = armed & lvl & ~lvl_prev;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl -- top-level game controller for a two-snake game.
//
// Converts the clear / pause / faster / slower keys into events, runs the
// IDLE/RUN/PAUSE/OVER state machine, divides the system clock into move
// ticks at the selected speed, and tracks which snake died first.
// Optional feature macro: GAME_CTRL_DEBOUNCE_EN (key debounce in key_edge).
//
// Ports:
//   clk        in  1   system clock, single domain
//   rst        in  1   asynchronous active-high reset
//   keystroke  in  12  raw keys; [8] clear, [9] pause, [10] faster, [11] slower
//   hit1       in  1   snake1 collision flag (level)
//   hit2       in  1   snake2 collision flag (level)
//   step1      out 1   one-cycle move strobe for snake1
//   step2      out 1   one-cycle move strobe for snake2
//   clear      out 1   one-cycle reinitialise pulse
//   clk_rate   out 2   speed level (00 4 Hz .. 11 0.5 Hz)
//   state      out 2   game state (also the FSM debug view)
//   winner     out 2   outcome, non-zero only in OVER
//
// step1, step2 and clear are fire-and-forget strobes: there is no
// valid/ready handshake and no backpressure; the receiver must act on the
// cycle the strobe is high.
module game_ctrl
  import game_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] keystroke,
  input  logic        hit1,
  input  logic        hit2,
  output logic        step1,
  output logic        step2,
  output logic        clear,
  output logic [1:0]  clk_rate,
  output logic [1:0]  state,
  output logic [1:0]  winner
);

  localparam int CW = $clog2(2 * CLK_HZ);

  // Last count value of a move period at each speed level.
  localparam logic [CW-1:0] LAST_4HZ  = CW'(CLK_HZ / 4 - 1);
  localparam logic [CW-1:0] LAST_2HZ  = CW'(CLK_HZ / 2 - 1);
  localparam logic [CW-1:0] LAST_1HZ  = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] LAST_HALF = CW'(2 * CLK_HZ - 1);

  // ---------------------------------------------------------------------
  // Key events
  // ---------------------------------------------------------------------
  logic ev_clear;
  logic ev_pause;
  logic ev_fast;
  logic ev_slow;

  key_edge #(.DEB_CYCLES(DEB_CYCLES)) u_key_clear (
    .clk(clk), .rst(rst), .key(keystroke[KEY_CLEAR]), .press(ev_clear)
  );
  key_edge #(.DEB_CYCLES(DEB_CYCLES)) u_key_pause (
    .clk(clk), .rst(rst), .key(keystroke[KEY_PAUSE]), .press(ev_pause)
  );
  key_edge #(.DEB_CYCLES(DEB_CYCLES)) u_key_fast (
    .clk(clk), .rst(rst), .key(keystroke[KEY_FAST]), .press(ev_fast)
  );
  key_edge #(.DEB_CYCLES(DEB_CYCLES)) u_key_slow (
    .clk(clk), .rst(rst), .key(keystroke[KEY_SLOW]), .press(ev_slow)
  );

  // The remaining keys belong to the snake datapaths.
  logic unused_keys;
  assign unused_keys = ^keystroke[7:0];

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  game_state_t   state_q;
  game_state_t   state_d;
  logic [1:0]    rate_q;
  logic [1:0]    rate_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_last;
  logic          terminal;
  logic          dead1_q;
  logic          dead2_q;
  logic          dead1_n;
  logic          dead2_n;
  logic          both_dead;
  logic          hit_window;
  winner_t       win_q;
  logic          clear_q;

  // ---------------------------------------------------------------------
  // Tick divider
  // ---------------------------------------------------------------------
  always_comb begin
    cnt_last = LAST_1HZ;
    case (rate_q)
      2'b00:   cnt_last = LAST_4HZ;
      2'b01:   cnt_last = LAST_2HZ;
      2'b10:   cnt_last = LAST_1HZ;
      default: cnt_last = LAST_HALF;
    endcase
  end

  // ">=" rather than "==" so that switching to a faster level while the
  // count is already past the new limit ends the period immediately.
  assign terminal = (cnt_q >= cnt_last);

  // A snake that is dead, or is being hit this very cycle, does not move.
  assign step1 = (state_q == ST_RUN) & terminal & ~dead1_q & ~hit1;
  assign step2 = (state_q == ST_RUN) & terminal & ~dead2_q & ~hit2;

  // ---------------------------------------------------------------------
  // Death tracking
  // ---------------------------------------------------------------------
  assign hit_window = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign dead1_n    = dead1_q | hit1;
  assign dead2_n    = dead2_q | hit2;
  assign both_dead  = dead1_q & dead2_q;

  // ---------------------------------------------------------------------
  // Speed level
  // ---------------------------------------------------------------------
  always_comb begin
    rate_d = rate_q;
    if (ev_fast && !ev_slow && rate_q != RATE_4HZ) begin
      rate_d = rate_q - 2'd1;
    end else if (ev_slow && !ev_fast && rate_q != RATE_HALF_HZ) begin
      rate_d = rate_q + 2'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Game FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (ev_clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (ev_pause) state_d = ST_RUN;
        ST_RUN: begin
          if (both_dead)     state_d = ST_OVER;
          else if (ev_pause) state_d = ST_PAUSE;
        end
        ST_PAUSE: if (ev_pause) state_d = ST_RUN;
        default:  state_d = ST_OVER;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_q  <= RATE_1HZ;
      cnt_q   <= '0;
      dead1_q <= 1'b0;
      dead2_q <= 1'b0;
      win_q   <= WIN_NONE;
      clear_q <= 1'b0;
    end else begin
      rate_q  <= rate_d;
      clear_q <= ev_clear;
      if (ev_clear) begin
        cnt_q   <= '0;
        dead1_q <= 1'b0;
        dead2_q <= 1'b0;
        win_q   <= WIN_NONE;
      end else begin
        if (state_q == ST_RUN) begin
          cnt_q <= terminal ? '0 : cnt_q + 1'b1;
        end
        if (hit_window) begin
          dead1_q <= dead1_n;
          dead2_q <= dead2_n;
          // Decide the winner on the cycle the second death lands; the
          // already-set flag tells which snake went first.
          if (dead1_n && dead2_n && !both_dead) begin
            if (dead1_q)      win_q <= WIN_SNAKE2;
            else if (dead2_q) win_q <= WIN_SNAKE1;
            else              win_q <= WIN_TIE;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign clear    = clear_q;
  assign clk_rate = rate_q;
  assign state    = state_q;
  assign winner   = (state_q == ST_OVER) ? win_q : WIN_NONE;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl -- randomized self-checking bench for game_ctrl.
//
// Inputs change 2 time units after each rising edge. A reference model
// runs at every falling edge: from the key history and the hit levels it
// predicts every output for the current cycle and pushes the packed
// prediction into exp_q, then advances its own game state. A monitor
// process, 1 time unit later, pops one prediction per cycle and compares
// it with what the DUT drives.
module tb_game_ctrl;

  localparam int CLK_HZ     = 8;
  localparam int DEB_CYCLES = 3;
  localparam int W          = 9;   // {step1, step2, clear, state, clk_rate, winner}

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_OVER  = 3;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] keystroke;
  logic        hit1;
  logic        hit2;
  logic        step1;
  logic        step2;
  logic        clear;
  logic [1:0]  clk_rate;
  logic [1:0]  state;
  logic [1:0]  winner;

  always #5 clk = ~clk;

  game_ctrl #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB_CYCLES)) dut (
    .clk(clk), .rst(rst), .keystroke(keystroke), .hit1(hit1), .hit2(hit2),
    .step1(step1), .step2(step2), .clear(clear), .clk_rate(clk_rate),
    .state(state), .winner(winner)
  );

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passed = 0;
  int cycle  = 0;

  // ---------------------------------------------------------------------
  // Reference model (game rules, cycle granularity)
  // ---------------------------------------------------------------------
  int m_state = M_IDLE;
  int m_rate  = 2;
  int m_cnt   = 0;        // cycles spent in RUN since the period started
  bit m_d1    = 0;
  bit m_d2    = 0;
  int m_win   = 0;
  bit m_clr   = 0;        // clear pulse expected in the current cycle
  bit kh[4][4];           // [key 8..11][age in cycles]
  bit ok_h[4];            // [age] : sample taken with rst low

  function automatic int period(input int r);
    case (r)
      0:       return CLK_HZ / 4;
      1:       return CLK_HZ / 2;
      2:       return CLK_HZ;
      default: return 2 * CLK_HZ;
    endcase
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_rate  = 2;
    m_cnt   = 0;
    m_d1    = 0;
    m_d2    = 0;
    m_win   = 0;
    m_clr   = 0;
  endtask

  task automatic model_step();
    bit ev[4];
    bit term, s1e, s2e, prev_both, n1, n2;
    logic [1:0] st2, rt2, wn2;
    // shift key history; a key's press is seen 3 cycles after it rises
    for (int a = 3; a > 0; a--) begin
      ok_h[a] = ok_h[a-1];
      for (int k = 0; k < 4; k++) kh[k][a] = kh[k][a-1];
    end
    ok_h[0] = !rst;
    for (int k = 0; k < 4; k++) kh[k][0] = keystroke[8+k];

    if (rst) begin
      model_reset();
      exp_q.push_back({1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0});
      return;
    end

    for (int k = 0; k < 4; k++) ev[k] = kh[k][2] && !kh[k][3] && ok_h[2] && ok_h[3];

    term = (m_state == M_RUN) && (m_cnt >= period(m_rate) - 1);
    s1e  = term && !m_d1 && !hit1;
    s2e  = term && !m_d2 && !hit2;
    st2  = 2'(m_state);
    rt2  = 2'(m_rate);
    wn2  = (m_state == M_OVER) ? 2'(m_win) : 2'd0;
    exp_q.push_back({s1e, s2e, m_clr, st2, rt2, wn2});

    // advance to the next cycle
    m_clr = ev[0];
    if (ev[2] && !ev[3] && m_rate > 0)      m_rate = m_rate - 1;
    else if (ev[3] && !ev[2] && m_rate < 3) m_rate = m_rate + 1;

    if (ev[0]) begin
      m_state = M_IDLE;
      m_cnt   = 0;
      m_d1    = 0;
      m_d2    = 0;
      m_win   = 0;
    end else begin
      prev_both = m_d1 && m_d2;
      if (m_state == M_RUN) m_cnt = term ? 0 : m_cnt + 1;
      if (m_state == M_RUN || m_state == M_PAUSE) begin
        n1 = m_d1 || hit1;
        n2 = m_d2 || hit2;
        if (n1 && n2 && !prev_both) m_win = m_d1 ? 2 : (m_d2 ? 1 : 3);
        m_d1 = n1;
        m_d2 = n2;
      end
      case (m_state)
        M_IDLE:  if (ev[1]) m_state = M_RUN;
        M_RUN:   if (prev_both) m_state = M_OVER; else if (ev[1]) m_state = M_PAUSE;
        M_PAUSE: if (ev[1]) m_state = M_RUN;
        default: m_state = M_OVER;
      endcase
    end
  endtask

  initial begin
    for (int a = 0; a < 4; a++) begin
      ok_h[a] = 0;
      for (int k = 0; k < 4; k++) kh[k][a] = 0;
    end
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  // ---------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    forever begin
      @(negedge clk);
      #1;
      cycle++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL no_expectation cyc=%0d got=%b required=an entry", cycle, a);
      end else begin
        e = exp_q.pop_front();
        a = {step1, step2, clear, state, clk_rate, winner};
        if (a === e) begin
          passed++;
        end else begin
          $display("FAIL outputs cyc=%0d got s1=%b s2=%b clr=%b st=%b rate=%b win=%b required s1=%b s2=%b clr=%b st=%b rate=%b win=%b",
                   cycle, a[8], a[7], a[6], a[5:4], a[3:2], a[1:0],
                   e[8], e[7], e[6], e[5:4], e[3:2], e[1:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // m bit0 clear, bit1 pause, bit2 faster, bit3 slower
  task automatic press(input logic [3:0] m);
    keystroke[11:8] = keystroke[11:8] | m;
    tick(2);
    keystroke[11:8] = keystroke[11:8] & ~m;
    tick(2);
  endtask

  // ---------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1);
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int r;
    rst       = 1'b1;
    keystroke = '0;
    hit1      = 1'b0;
    hit2      = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(5);

    // start, run at the default 1 Hz level
    press(4'b0010);
    tick(30);
    // faster three times (saturates), then faster+slower together
    press(4'b0100);
    press(4'b0100);
    press(4'b0100);
    tick(10);
    press(4'b1100);
    tick(6);
    press(4'b1000);
    press(4'b1000);
    tick(10);
    // pause, hold, resume
    press(4'b0010);
    tick(10);
    press(4'b0010);
    tick(10);
    // snake1 dies first, then snake2
    hit1 = 1'b1;
    tick(12);
    hit2 = 1'b1;
    tick(6);
    hit1 = 1'b0;
    hit2 = 1'b0;
    press(4'b0010);            // pause in OVER does nothing
    tick(4);
    press(4'b0011);            // clear and pause together
    tick(4);
    // both die in the same cycle
    press(4'b0010);
    tick(7);
    hit1 = 1'b1;
    hit2 = 1'b1;
    tick(4);
    hit1 = 1'b0;
    hit2 = 1'b0;
    press(4'b0001);
    tick(3);

    // randomized play
    for (int i = 0; i < 250; i++) begin
      keystroke[7:0] = 8'($urandom);
      r = $urandom_range(0, 11);
      case (r)
        0, 1, 2: press(4'b0010);
        3:       press(4'b0100);
        4:       press(4'b1000);
        5:       press(4'b1100);
        6: begin
          hit1 = 1'b0;
          hit2 = 1'b0;
          press(($urandom_range(0, 3) == 0) ? 4'b0011 : 4'b0001);
        end
        7:  hit1 = ($urandom_range(0, 2) == 0);
        8:  hit2 = ($urandom_range(0, 2) == 0);
        9: begin
          hit1 = 1'b0;
          hit2 = 1'b0;
          tick(1);
        end
        default: tick($urandom_range(1, 20));
      endcase
    end
    hit1 = 1'b0;
    hit2 = 1'b0;
    keystroke = '0;
    press(4'b0001);
    tick(3);

    // reset in the middle of a period with pause held through reset
    press(4'b0010);
    tick($urandom_range(3, 9));
    keystroke[9] = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(12);
    keystroke[9] = 1'b0;
    tick(4);
    press(4'b0010);
    tick(20);

    tick(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter DEB_CYCLES, default 500_000, debounce stability window in clk cycles (used only under REQ-027).
REQ-003 SHALL have port clk  input  1  system clock; one clock domain.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port keystroke  input  12  raw keys; only [8] clear, [9] pause/resume, [10] faster, [11] slower used.
REQ-006 SHALL have port hit1  input  1  snake1 collision/stop flag, level.
REQ-007 SHALL have port hit2  input  1  snake2 collision/stop flag, level.
REQ-008 SHALL have port step1  output  1  one-cycle move strobe to snake1 datapath.
REQ-009 SHALL have port step2  output  1  one-cycle move strobe to snake2 datapath.
REQ-010 SHALL have port clear  output  1  one-cycle pulse reinitialising snakes, food, scores.
REQ-011 SHALL have port clk_rate  output  2  speed level: 00=4 Hz, 01=2 Hz, 10=1 Hz, 11=0.5 Hz.
REQ-012 SHALL have port state  output  2  game state: 00 IDLE, 01 RUN, 10 PAUSE, 11 OVER.
REQ-013 SHALL have port winner  output  2  00 none, 01 snake1, 10 snake2, 11 tie; valid in OVER.

Function
REQ-014 Keys [11:8] SHALL pass a 2-flop synchroniser, then rising-edge detection; each press yields exactly one internal one-cycle event, 3 cycles after the raw edge.
REQ-015 FSM: IDLE -pause-> RUN; RUN -pause-> PAUSE; PAUSE -pause-> RUN; RUN -both dead-> OVER; OVER -pause-> no effect; clear event from any state -> IDLE.
REQ-016 Clear event SHALL assert clear for exactly one cycle, zero the tick counter, clear dead1/dead2 and winner; clk_rate retained; clear wins over simultaneous pause.
REQ-017 Tick counter SHALL increment only in RUN; period P = CLK_HZ/4, /2, x1, x2 for clk_rate 00..11; terminal when count >= P-1, then wraps to 0; width $clog2(2*CLK_HZ).
REQ-018 On terminal tick in RUN: step1 asserts one cycle iff dead1=0 that cycle; step2 likewise with dead2.
REQ-019 dead1/dead2 SHALL be sticky, set on hit1/hit2 high in RUN or PAUSE, cleared only by clear event or rst; a step in the same cycle hit rises SHALL be suppressed.
REQ-020 When dead1 and dead2 both set, state SHALL become OVER next cycle; winner = 01 if dead2 set strictly earlier, 10 if dead1 earlier, 11 if same cycle.
REQ-021 Faster event SHALL decrement clk_rate saturating at 00; slower increments saturating at 11; both in same cycle: no change; accepted in every state; counter not reset (REQ-017 >= compare handles shrink).
REQ-022 step1/step2 SHALL never assert outside RUN; PAUSE freezes the counter value.

Reset
REQ-023 rst SHALL asynchronously force state=IDLE, clk_rate=10, step1=step2=0, clear=0, winner=00, dead flags, counter, synchroniser and edge flops to 0.
REQ-024 After rst deasserts, no key event SHALL be generated for a key held high through reset.
REQ-025 rst mid-tick SHALL discard the partial period; first post-reset RUN period is a full P.

Configuration
REQ-026 Without GAME_CTRL_DEBOUNCE_EN: edge detection directly on synchronised keys (REQ-014).
REQ-027 With GAME_CTRL_DEBOUNCE_EN: each key SHALL be stable for DEB_CYCLES consecutive cycles before its filtered level changes; edge detection on filtered level; latency becomes 3+DEB_CYCLES cycles.

Structure
REQ-028 Package game_pkg SHALL hold the state encoding, clk_rate encoding, winner encoding and key bit indices (KEY_CLEAR=8, KEY_PAUSE=9, KEY_FAST=10, KEY_SLOW=11).
REQ-029 Sub-module key_edge (synchroniser, optional debounce, rising-edge pulse) SHALL be instantiated four times; FSM, counter and arbitration stay in game_ctrl.

Verification (CLK_HZ=8, DEB_CYCLES=3)
REQ-030 rst, pulse [9] -> state 01 after 3 cycles; step1,step2 pulse every 8 cycles (clk_rate 10).
REQ-031 In RUN, pulse [10] twice then [10] again -> clk_rate 00, saturates; steps every 2 cycles; [10]+[11] same cycle -> clk_rate unchanged.
REQ-032 hit1 high in RUN -> step1 stops, step2 continues; later hit2 -> state 11, winner 10 next cycle.
REQ-033 hit1 and hit2 same cycle -> state 11, winner 11; [9] in OVER -> no change; [8]+[9] same cycle -> clear pulse 1 cycle, state 00.
REQ-034 [9] in RUN at count 5 -> state 10, no steps, counter held at 5; [9] again -> resumes, step after 3 more cycles.
REQ-035 rst asserted mid-period with [9] held -> all outputs reset immediately; release rst, keep [9] high -> state stays 00.
